// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-stage initiator between execute stage and synchronous data memory
// One request in flight; drives memory strobes and emits one write-back packet per accepted request.
module mem_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 6,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic              req_mem_to_reg,
  input  logic              req_reg_write,
  input  logic [REG_W-1:0]  req_rd,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_alu_result,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, WB} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t              state;
  logic                l_load;
  logic                l_store;
  logic                l_mem_to_reg;
  logic                l_reg_write;
  logic [REG_W-1:0]    l_rd;
  logic [DATA_W-1:0]   l_alu;
  logic [2:0]          wait_cnt;

  assign req_ready = (state == IDLE) & resetn;
  assign busy      = (state != IDLE);

  // Outputs are registered, so each state's outputs are loaded on the edge that enters it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      l_load       <= 1'b0;
      l_store      <= 1'b0;
      l_mem_to_reg <= 1'b0;
      l_reg_write  <= 1'b0;
      l_rd         <= '0;
      l_alu        <= '0;
      wait_cnt     <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_address  <= '0;
      mem_datain   <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      wb_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            // A request flagged as both load and store is treated as a store.
            l_load       <= req_load & ~req_store;
            l_store      <= req_store;
            l_mem_to_reg <= req_mem_to_reg;
            l_reg_write  <= req_reg_write;
            l_rd         <= req_rd;
            l_alu        <= req_alu_result;
            if (req_store) begin
              mem_write   <= 1'b1;
              mem_address <= req_addr;
              mem_datain  <= req_wdata;
              state       <= ACCESS;
            end else if (req_load) begin
              mem_read    <= 1'b1;
              mem_address <= req_addr;
              state       <= ACCESS;
            end else begin
              wb_valid     <= 1'b1;
              wb_reg_write <= req_reg_write;
              wb_rd        <= req_rd;
              wb_data      <= req_alu_result;
              state        <= WB;
            end
          end
        end
        ACCESS: begin
          if (l_load) begin
            wait_cnt <= CNT_INIT;
            state    <= WAIT;
          end else begin
            wb_valid     <= 1'b1;
            wb_reg_write <= l_reg_write & ~l_store;
            wb_rd        <= l_rd;
            wb_data      <= l_alu;
            state        <= WB;
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= l_reg_write;
            wb_rd        <= l_rd;
            wb_data      <= l_mem_to_reg ? mem_dataout : l_alu;
            state        <= WB;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        WB: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - bench for mem_access_ctrl with MEM_LAT=1 and MEM_LAT=3 instances
// Each instance has its own word-indexed memory; a shadow array predicts every write-back.
module tb_mem_access_ctrl;
  localparam int DW = 32;
  localparam int RW = 6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          resetn;
  logic          preload;
  logic [1:0]    req_valid, req_ready, req_load, req_store, req_m2r, req_rw;
  logic [1:0]    mem_read, mem_write, wb_valid, wb_rw, busy;
  logic [RW-1:0] req_rd [2];
  logic [RW-1:0] wb_rd [2];
  logic [DW-1:0] req_addr [2], req_wdata [2], req_alu [2];
  logic [DW-1:0] mem_address [2], mem_datain [2], mem_dataout [2], wb_data [2];

  mem_access_ctrl #(.DATA_W(DW), .REG_W(RW), .MEM_LAT(1)) u_dut_lat1 (
    .clock(clock), .resetn(resetn), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_load(req_load[0]), .req_store(req_store[0]), .req_mem_to_reg(req_m2r[0]),
    .req_reg_write(req_rw[0]), .req_rd(req_rd[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_alu_result(req_alu[0]), .mem_read(mem_read[0]),
    .mem_write(mem_write[0]), .mem_address(mem_address[0]), .mem_datain(mem_datain[0]),
    .mem_dataout(mem_dataout[0]), .wb_valid(wb_valid[0]), .wb_reg_write(wb_rw[0]),
    .wb_rd(wb_rd[0]), .wb_data(wb_data[0]), .busy(busy[0]));

  mem_access_ctrl #(.DATA_W(DW), .REG_W(RW), .MEM_LAT(3)) u_dut_lat3 (
    .clock(clock), .resetn(resetn), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_load(req_load[1]), .req_store(req_store[1]), .req_mem_to_reg(req_m2r[1]),
    .req_reg_write(req_rw[1]), .req_rd(req_rd[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_alu_result(req_alu[1]), .mem_read(mem_read[1]),
    .mem_write(mem_write[1]), .mem_address(mem_address[1]), .mem_datain(mem_datain[1]),
    .mem_dataout(mem_dataout[1]), .wb_valid(wb_valid[1]), .wb_reg_write(wb_rw[1]),
    .wb_rd(wb_rd[1]), .wb_data(wb_data[1]), .busy(busy[1]));

  function automatic logic [DW-1:0] init_word(int i);
    case (i)
      2:       return 32'd30;
      3:       return 32'd19;
      4:       return 32'd6;
      default: return 32'hA000_0000 + 32'(i);
    endcase
  endfunction

  // Synchronous memories: read data appears MEM_LAT edges after the edge sampling mem_read.
  logic [DW-1:0] mem [2][16];
  logic [DW-1:0] pipe_a;
  logic [DW-1:0] pipe_b [3];
  always @(posedge clock) begin
    if (preload) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 16; i++) mem[d][i] <= init_word(i);
    end else begin
      if (mem_write[0]) mem[0][mem_address[0][3:0]] <= mem_datain[0];
      if (mem_write[1]) mem[1][mem_address[1][3:0]] <= mem_datain[1];
    end
    if (mem_read[0]) pipe_a <= mem[0][mem_address[0][3:0]];
    if (mem_read[1]) pipe_b[0] <= mem[1][mem_address[1][3:0]];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mem_dataout[0] = pipe_a;
  assign mem_dataout[1] = pipe_b[2];

  logic [DW-1:0] shadow [2][16];
  int vectors = 0;
  int errors  = 0;

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int d, bit ld, bit st, bit m2r, bit rw, logic [RW-1:0] rd,
                       logic [DW-1:0] addr, logic [DW-1:0] wdata, logic [DW-1:0] alu);
    req_load[d] = ld; req_store[d] = st; req_m2r[d] = m2r; req_rw[d] = rw;
    req_rd[d] = rd; req_addr[d] = addr; req_wdata[d] = wdata; req_alu[d] = alu;
  endtask

  task automatic run_req(int d, int lat, bit ld, bit st, bit m2r, bit rw, logic [RW-1:0] rd,
                         logic [DW-1:0] addr, logic [DW-1:0] wdata, logic [DW-1:0] alu);
    int waits = 0, k = 0, nrd = 0, nwr = 0, nwb = 0, wb_at = 0, overlap = 0, exp_lat;
    bit eff_ld, done = 0;
    logic [DW-1:0] exp_data, got_data = '0, strobe_addr = '0, strobe_wdata = '0;
    logic [RW-1:0] got_rd = '0;
    logic got_rw = 1'b0;
    @(negedge clock);
    drive(d, ld, st, m2r, rw, rd, addr, wdata, alu);
    req_valid[d] = 1'b1;
    while (!req_ready[d] && waits < 50) begin @(negedge clock); waits++; end
    check("accept_bound", 32'(waits < 50), 32'd1);
    @(posedge clock);
    #1 req_valid[d] = 1'b0;
    eff_ld   = ld & ~st;
    exp_data = (eff_ld && m2r) ? shadow[d][addr[3:0]] : alu;
    exp_lat  = st ? 2 : (eff_ld ? 2 + lat : 1);
    if (st) shadow[d][addr[3:0]] = wdata;
    while (!done && k < 40) begin
      @(negedge clock);
      k++;
      if (mem_read[d] && mem_write[d]) overlap++;
      if (mem_read[d]) begin nrd++; strobe_addr = mem_address[d]; end
      if (mem_write[d]) begin nwr++; strobe_addr = mem_address[d]; strobe_wdata = mem_datain[d]; end
      if (wb_valid[d]) begin
        nwb++;
        if (nwb == 1) begin wb_at = k; got_data = wb_data[d]; got_rd = wb_rd[d]; got_rw = wb_rw[d]; end
      end
      if (!busy[d]) done = 1;
    end
    check("complete_bound", 32'(done), 32'd1);
    check("wb_latency", 32'(wb_at), 32'(exp_lat));
    check("wb_pulses", 32'(nwb), 32'd1);
    check("wb_data", got_data, exp_data);
    check("wb_rd", 32'(got_rd), 32'(rd));
    check("wb_reg_write", 32'(got_rw), 32'(rw & ~st));
    check("read_pulses", 32'(nrd), 32'(eff_ld));
    check("write_pulses", 32'(nwr), 32'(st));
    check("strobe_overlap", 32'(overlap), 32'd0);
    if (ld || st) check("mem_address", strobe_addr, addr);
    if (st) check("mem_datain", strobe_wdata, wdata);
    check("wb_data_hold", wb_data[d], exp_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, accepts, k;
    bit second;
    logic [DW-1:0] got [$];
    resetn = 1'b0; preload = 1'b1; req_valid = '0;
    for (int d = 0; d < 2; d++) begin
      drive(d, 0, 0, 0, 0, '0, '0, '0, '0);
      for (int i = 0; i < 16; i++) shadow[d][i] = init_word(i);
    end

    // Reset state
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        check("rst_req_ready", 32'(req_ready[d]), 32'd0);
        check("rst_strobes", 32'({mem_read[d], mem_write[d], wb_valid[d], wb_rw[d], busy[d]}), 32'd0);
        check("rst_mem_address", mem_address[d], '0);
        check("rst_wb_data", wb_data[d], '0);
      end
    end
    resetn = 1'b1; preload = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check("post_rst_ready", 32'(req_ready[d]), 32'd1);
      check("post_rst_busy", 32'(busy[d]), 32'd0);
    end

    // Directed: load, store/load, ALU-only, load+store collision
    run_req(0, 1, 1, 0, 1, 1, 6'd5, 32'd2, 32'd0, 32'h55);
    run_req(0, 1, 0, 1, 0, 1, 6'd1, 32'd7, 32'hDEADBEEF, 32'h11);
    run_req(0, 1, 1, 0, 1, 1, 6'd9, 32'd7, 32'd0, 32'h22);
    run_req(0, 1, 0, 0, 0, 1, 6'd3, 32'd0, 32'd0, 32'h28);
    run_req(0, 1, 1, 1, 1, 1, 6'd4, 32'd9, 32'h1234_5678, 32'h33);
    run_req(1, 3, 1, 0, 1, 1, 6'd8, 32'd2, 32'd0, 32'h44);

    // Back-to-back loads with req_valid held high throughout
    @(negedge clock);
    drive(0, 1, 0, 1, 1, 6'd10, 32'd3, 32'd0, 32'd0);
    req_valid[0] = 1'b1;
    @(posedge clock);
    #1 drive(0, 1, 0, 1, 1, 6'd11, 32'd4, 32'd0, 32'd0);
    gap = 0; accepts = 1; second = 0; k = 0;
    while (k < 40 && !(second && !busy[0] && got.size() >= 2)) begin
      @(negedge clock);
      k++;
      if (wb_valid[0]) got.push_back(wb_data[0]);
      if (second) req_valid[0] = 1'b0;
      if (req_valid[0] && req_ready[0]) begin accepts++; second = 1; gap = k; end
    end
    check("b2b_bound", 32'(k < 40), 32'd1);
    check("b2b_accepts", 32'(accepts), 32'd2);
    check("b2b_gap", 32'(gap), 32'd4);
    check("b2b_wb_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("b2b_first", got[0], shadow[0][3]);
      check("b2b_second", got[1], shadow[0][4]);
    end

    // Reset during WAIT on the MEM_LAT=3 instance
    @(negedge clock);
    drive(1, 1, 0, 1, 1, 6'd12, 32'd5, 32'd0, 32'd0);
    req_valid[1] = 1'b1;
    @(posedge clock);
    #1 req_valid[1] = 1'b0;
    @(negedge clock);
    check("mid_access_read", 32'(mem_read[1]), 32'd1);
    @(negedge clock);
    check("mid_wait_busy", 32'(busy[1]), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_read", 32'(mem_read[1]), 32'd0);
    check("mid_rst_busy", 32'(busy[1]), 32'd0);
    check("mid_rst_ready", 32'(req_ready[1]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("mid_rst_no_wb", 32'(wb_valid[1]), 32'd0);
    end
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("post_rst_no_wb", 32'(wb_valid[1]), 32'd0);
    end
    run_req(1, 3, 1, 0, 1, 1, 6'd12, 32'd5, 32'd0, 32'd0);

    // Randomized requests on both instances against the shadow memory
    for (int n = 0; n < 30; n++) begin
      int d;
      logic [DW-1:0] addr;
      d = int'($urandom_range(0, 1));
      addr = {$urandom_range(0, 3) == 0 ? $urandom() : 32'd0} & 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      run_req(d, d == 0 ? 1 : 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom()),
              addr, $urandom(), $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory-stage initiator that sits between the execute stage and the synchronous data memory, which responds to read/write strobes. It accepts one execute-stage result per valid/ready handshake and drives the memory read/write strobe, address and write data. For loads it waits out the memory's registered-read latency and captures the returned word. It emits one write-back packet per accepted request, selecting either the memory data or the ALU result.

Parameters:
DATA_W, 32, width of address, write data, read data and ALU result
REG_W, 6, register index width
MEM_LAT, 1, cycles from the clock edge that samples mem_read to the edge where mem_dataout is captured; legal range 1..7

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  execute stage presents a request
req_ready  out  1  block can accept a request
req_load  in  1  request is a load (memRead)
req_store  in  1  request is a store (memWrite)
req_mem_to_reg  in  1  write-back takes memory data
req_reg_write  in  1  request writes a register
req_rd  in  REG_W  destination register index
req_addr  in  DATA_W  memory address
req_wdata  in  DATA_W  store data
req_alu_result  in  DATA_W  ALU result
mem_read  out  1  read strobe to the data memory
mem_write  out  1  write strobe to the data memory
mem_address  out  DATA_W  memory address
mem_datain  out  DATA_W  memory write data
mem_dataout  in  DATA_W  memory read data, registered inside the memory
wb_valid  out  1  one-cycle write-back pulse
wb_reg_write  out  1  register-file write enable, qualified by wb_valid
wb_rd  out  REG_W  write-back register index
wb_data  out  DATA_W  write-back data
busy  out  1  request in flight

Behaviour:
- Reset:
  - Reset is asynchronous and active-low on resetn, clocked by clock.
  - On resetn low, state goes to IDLE and every registered output clears to 0 immediately.
  - req_ready is forced 0 while resetn is low.
- State machine states: IDLE, ACCESS, WAIT, WB.
- All outputs except req_ready and busy are registered. req_ready = (state==IDLE) & resetn. busy = (state!=IDLE).
- IDLE:
  - On req_valid & req_ready, latch all req_* fields.
  - If req_store or req_load, go to ACCESS. Otherwise go to WB.
- Load and store asserted together: the store wins and the load is ignored.
- ACCESS (exactly one cycle):
  - mem_address = latched address.
  - Store: mem_write=1, mem_datain = latched wdata, mem_read=0.
  - Load: mem_read=1, mem_write=0.
  - Next state is WAIT for a load, WB for a store.
- WAIT:
  - A counter loads MEM_LAT-1 on entry and decrements each cycle.
  - When the counter is 0, capture mem_dataout into the load register and go to WB.
  - With MEM_LAT=1, the capture happens on the single WAIT cycle.
- WB (exactly one cycle):
  - wb_valid=1, wb_rd = latched rd.
  - wb_reg_write = latched reg_write & ~latched store.
  - wb_data = (latched load & mem_to_reg) ? captured data : latched alu_result.
  - Next state is IDLE.
- Latency, counted from the accepting edge to the cycle wb_valid is high:
  - ALU-only: 1 cycle.
  - Store: 2 cycles.
  - Load: 2+MEM_LAT cycles.
- Non-pipelined: at most one request in flight. A req_valid held while busy is not accepted, and the request stays pending until the block returns to IDLE.
- mem_read and mem_write are never high simultaneously. Each is high for at most one cycle per request.
- mem_address and mem_datain hold their last driven values outside ACCESS. Their reset value is 0.
- wb_valid pulses exactly once per accepted request, stores included.
- wb_rd and wb_data hold their values after the pulse until the next WB.
- Address arithmetic: none. The address passes through unmodified; the memory uses it as a word index.
- Reset mid-operation: the in-flight request is dropped, no wb_valid is produced, and strobes deassert asynchronously.

Test Plan:
1. Hold resetn=0 for 3 cycles, then release -> all outputs 0 during reset and req_ready=0; after release, req_ready=1 and busy=0.
2. Memory preloaded with word 2=30. Load, addr=2, rd=5, mem_to_reg=1, reg_write=1, MEM_LAT=1 -> mem_read high for exactly 1 cycle with mem_address=2; wb_valid 3 cycles after acceptance with wb_data=30, wb_rd=5, wb_reg_write=1.
3. Store addr=7, wdata=0xDEADBEEF, reg_write=1, then load addr=7 into rd=9 -> store: mem_write for 1 cycle, then wb_valid with wb_reg_write=0. Load: wb_data=0xDEADBEEF.
4. ALU-only request, alu_result=0x28, rd=3, reg_write=1 -> no memory strobe; wb_valid 1 cycle after acceptance with wb_data=0x28, wb_rd=3. Also run with load and store both set -> only mem_write pulses.
5. Keep req_valid high across two back-to-back loads (addr 3 then 4) -> second acceptance occurs only when state returns to IDLE; exactly two wb_valid pulses, carrying 19 then 6.
6. Drop resetn during WAIT of a load with MEM_LAT=3 -> mem_read and busy go to 0 immediately; no wb_valid; next request after release completes normally.
